// File: rtl/dig_divider_scheduler_pkg.sv
// Shared types for the divider scheduler: FSM state encoding and channel-select width.
package divsched_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_RUN} state_t;

   // Channel-select width, never narrower than one bit so a single-channel build still has a port.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dig_divider_channel.sv
// One divider channel: counts 0..div in RUN and emits a tick at terminal count; optional sq (DIVSCHED_SQ_OUT_EN).
// Latency: tick is combinational from the registered counter; reloads land at the next terminal count (or next cycle when stopped).
// Backpressure: pending flag stays set until the staged divisor is applied; the top stalls further writes on it.
module dig_divider_channel #(
   parameter int WIDTH       = 32,
   parameter int DEFAULT_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_div,
   output logic             tick,
   output logic             pending
`ifdef DIVSCHED_SQ_OUT_EN
   ,
   output logic             sq
`endif
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div;
   logic [WIDTH-1:0] pend_div;
   logic             term;

   assign term = (cnt == div);
   assign tick = run & ~clear & term;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         div      <= WIDTH'(DEFAULT_DIV);
         pend_div <= '0;
         pending  <= 1'b0;
      end else begin
         if (clear) begin
            cnt <= '0;
         end else if (run) begin
            cnt <= term ? '0 : cnt + WIDTH'(1);
         end
         // A write is only accepted while pending is clear, so staging and applying never collide.
         if (wr_en) begin
            pend_div <= wr_div;
            pending  <= 1'b1;
         end else if (pending && (clear || tick)) begin
            div     <= pend_div;
            pending <= 1'b0;
         end
      end
   end

`ifdef DIVSCHED_SQ_OUT_EN
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sq <= 1'b0;
      end else if (tick) begin
         sq <= ~sq;
      end
   end
`endif

endmodule

// File: rtl/dig_divider_scheduler.sv
// Multi-channel clock-enable scheduler with start/stop phase alignment; sq outputs under DIVSCHED_SQ_OUT_EN.
// Latency: busy one cycle after start; first tick div+1 cycles after RUN entry (one ALIGN cycle between).
// Backpressure: cfg_ready drops while the addressed channel still holds an unapplied divisor.
module dig_divider_scheduler
   import divsched_pkg::*;
#(
   parameter  int CHANNELS    = 4,
   parameter  int WIDTH       = 32,
   parameter  int DEFAULT_DIV = 1,
   localparam int CH_W        = ch_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   output logic                busy,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WIDTH-1:0]    cfg_div,
   output logic [CHANNELS-1:0] tick
`ifdef DIVSCHED_SQ_OUT_EN
   ,
   output logic [CHANNELS-1:0] sq
`endif
);

   state_t              state;
   state_t              state_nxt;
   logic                run;
   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] wr_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // stop wins over start; start outside IDLE is ignored.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start && !stop) state_nxt = ST_ALIGN;
         ST_ALIGN: state_nxt = stop ? ST_IDLE : ST_RUN;
         ST_RUN:   if (stop) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign run  = (state == ST_RUN);

   // Out-of-range channel numbers match nothing: ready stays 1 and the write is dropped.
   always_comb begin
      cfg_ready = 1'b1;
      wr_en     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = ~pending[i];
            wr_en[i]  = cfg_valid & ~pending[i];
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      dig_divider_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .run     (run),
         .clear   (~run),
         .wr_en   (wr_en[g]),
         .wr_div  (cfg_div),
         .tick    (tick[g]),
         .pending (pending[g])
`ifdef DIVSCHED_SQ_OUT_EN
         ,
         .sq      (sq[g])
`endif
      );
   end

endmodule

// File: tb/tb_dig_divider_scheduler.sv
// Scoreboarded bench for dig_divider_scheduler: a behavioural model queues expected outputs per cycle.
module tb_dig_divider_scheduler;

   localparam int CH = 3;
   localparam int W  = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic          busy;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_ch;
   logic [W-1:0]  cfg_div;
   logic [CH-1:0] tick;
`ifdef DIVSCHED_SQ_OUT_EN
   logic [CH-1:0] sq;
`endif

   dig_divider_scheduler #(
      .CHANNELS    (CH),
      .WIDTH       (W),
      .DEFAULT_DIV (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .busy      (busy),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .tick      (tick)
`ifdef DIVSCHED_SQ_OUT_EN
      ,
      .sq        (sq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH-1:0] tick;
      logic          busy;
      logic          ready;
      logic [CH-1:0] sq;
   } exp_t;

   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // model state: 0 idle, 1 align, 2 run
   int m_st;
   int m_cnt[CH];
   int m_div[CH];
   int m_pdiv[CH];
   bit m_pend[CH];
   bit m_sq[CH];

   int            run_cyc;
   logic [CH-1:0] last_tick;
   logic          last_busy;
   logic          last_ready;
   logic [CH-1:0] last_sq;
   int            t2_pos[$];
   int            hi_cnt;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0;
      for (int i = 0; i < CH; i++) begin
         m_cnt[i]  = 0;
         m_div[i]  = 1;
         m_pdiv[i] = 0;
         m_pend[i] = 0;
         m_sq[i]   = 0;
      end
   endtask

   // One clock cycle: drive inputs, queue the expected outputs, compare at negedge, advance the model.
   task automatic step(input logic s, input logic p, input logic v, input logic [1:0] ch,
                       input logic [W-1:0] d, input logic r);
      exp_t e;
      exp_t got;
      bit   acc;
      start = s; stop = p; cfg_valid = v; cfg_ch = ch; cfg_div = d; rst = r;
      e.busy  = (m_st != 0);
      e.ready = (ch < CH) ? !m_pend[ch] : 1'b1;
      for (int i = 0; i < CH; i++) begin
         e.tick[i] = (m_st == 2) && (m_cnt[i] == m_div[i]);
         e.sq[i]   = m_sq[i];
      end
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         got = exp_q.pop_front();
         check("tick", tick, got.tick);
         check("busy", busy, got.busy);
         check("cfg_ready", cfg_ready, got.ready);
`ifdef DIVSCHED_SQ_OUT_EN
         check("sq", sq, got.sq);
`endif
      end
      last_tick = tick; last_busy = busy; last_ready = cfg_ready;
`ifdef DIVSCHED_SQ_OUT_EN
      last_sq = sq;
`else
      last_sq = '0;
`endif
      run_cyc = (m_st == 2) ? run_cyc + 1 : 0;
      if (m_st == 2 && tick[2]) t2_pos.push_back(run_cyc);
      acc = v && e.ready;
      if (r) begin
         model_reset();
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (m_st == 2) begin
               if (e.tick[i]) begin
                  m_cnt[i] = 0;
                  m_sq[i]  = !m_sq[i];
                  if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
               end else begin
                  m_cnt[i]++;
               end
            end else begin
               m_cnt[i] = 0;
               m_sq[i]  = 0;
               if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
            end
            if (acc && ch == i) begin m_pdiv[i] = int'(d); m_pend[i] = 1; end
         end
         case (m_st)
            0: if (s && !p) m_st = 1;
            1: m_st = p ? 0 : 2;
            default: if (p) m_st = 0;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 2'd0, '0, 0);
   endtask

   initial begin
      run_cyc = 0;
      rst = 1; start = 0; stop = 0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_tick", tick, 0);
      check("rst_ready", cfg_ready, 1);
      rst = 0;

      // T1: default divisor, all channels in phase
      step(1, 0, 0, 2'd0, '0, 0);
      step(0, 0, 0, 2'd0, '0, 0);
      check("t1_busy_align", last_busy, 1);
      step(0, 0, 0, 2'd0, '0, 0);
      check("t1_run1_tick", last_tick, 3'b000);
      step(0, 0, 0, 2'd0, '0, 0);
      check("t1_run2_tick", last_tick, 3'b111);
      idle(7);
      step(0, 1, 0, 2'd0, '0, 0);
      idle(2);
      check("t1_stopped", last_busy, 0);

      // T2: ch2 div=4 written in IDLE
      step(0, 0, 1, 2'd2, 32'd4, 0);
      check("t2_accept", last_ready, 1);
      idle(1);
      t2_pos.delete();
      step(1, 0, 0, 2'd0, '0, 0);
      idle(17);
      check("t2_ntick", t2_pos.size(), 3);
      if (t2_pos.size() >= 3) begin
         check("t2_tick_a", t2_pos[0], 5);
         check("t2_tick_b", t2_pos[1], 10);
         check("t2_tick_c", t2_pos[2], 15);
      end
      step(0, 1, 0, 2'd0, '0, 0);
      idle(1);
      check("t4_stop_tick", last_tick, 0);

      // T3: ch0 div=2 then div=0 one cycle before terminal
      step(0, 0, 1, 2'd0, 32'd2, 0);
      idle(1);
      step(1, 0, 0, 2'd0, '0, 0);
      idle(1);
      idle(1);
      step(0, 0, 1, 2'd0, 32'd0, 0);
      check("t3_accept", last_ready, 1);
      step(0, 0, 1, 2'd0, 32'd2, 0);
      check("t3_stall", last_ready, 0);
      check("t3_old_tick", last_tick[0], 1);
      step(0, 0, 1, 2'd0, 32'd2, 0);
      check("t3_accept2", last_ready, 1);
      check("t3_fast_tick", last_tick[0], 1);
      step(0, 0, 0, 2'd0, '0, 0);
      check("t3_fast_tick2", last_tick[0], 1);
      idle(6);
      step(0, 0, 1, 2'd3, 32'd7, 0);
      check("oor_ready", last_ready, 1);
      idle(3);
      step(0, 1, 0, 2'd0, '0, 0);

      // T4: start and stop together in IDLE
      step(1, 1, 0, 2'd0, '0, 0);
      step(0, 0, 0, 2'd0, '0, 0);
      check("t4_busy", last_busy, 0);
      check("t4_tick", last_tick, 0);

      // T5: reset mid-RUN with a write pending on ch2
      step(1, 0, 0, 2'd0, '0, 0);
      idle(3);
      step(0, 0, 1, 2'd2, 32'd9, 0);
      step(0, 0, 0, 2'd2, '0, 1);
      step(0, 0, 0, 2'd2, '0, 0);
      check("t5_busy", last_busy, 0);
      check("t5_tick", last_tick, 0);
      check("t5_ready", last_ready, 1);
      step(1, 0, 0, 2'd0, '0, 0);
      idle(2);
      step(0, 0, 0, 2'd0, '0, 0);
      check("t5_default_div", last_tick, 3'b111);
      step(0, 1, 0, 2'd0, '0, 0);
      idle(1);

`ifdef DIVSCHED_SQ_OUT_EN
      // T6: square wave period 8 at div=3
      step(0, 0, 1, 2'd0, 32'd3, 0);
      idle(1);
      step(1, 0, 0, 2'd0, '0, 0);
      idle(1);
      hi_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         idle(1);
         if (last_sq[0]) hi_cnt++;
      end
      check("t6_duty", hi_cnt, 8);
      step(0, 1, 0, 2'd0, '0, 0);
      idle(1);
      check("t6_sq_idle", last_sq, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
